decade_count_monitor: RTL and testbench

Receive-side companion to the team's 4-bit decade counter: samples the counter's `en` and `count` outputs every clock, predicts the next value, and flags any deviation from the legal sequence (hold when `en`=0, +1 when `en`=1, 9 wraps to 0). Provides lock status, error pulse, sticky error, saturating error and wrap counters. Sits beside any decade-counter instance as an on-chip checker, and is reused as the scoreboard in counter benches.

---
 rtl/decade_count_monitor.sv | 129 ++++++++++++
 tb/tb_decade_count_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decade_count_monitor.sv
// rtl/decade_count_monitor.sv - sequence checker for a 4-bit decade counter
// Predicts the next count from each (en, count) sample and flags deviations once locked.
module decade_count_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [3:0]        count,
  input  logic              clear,
  output logic [3:0]        expected,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              illegal
);

  localparam int MW = $clog2(LOCK_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRAIN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state, state_d;
  logic [MW-1:0] mcnt, mcnt_d;
  logic          prev_nine;
  logic          is_illegal, is_match, err_d, wrap_d;
  logic [3:0]    pred_d;

  always_comb begin
    is_illegal = (count > 4'd9);
    is_match   = (count == expected);
    if (is_illegal)
      pred_d = 4'd0;
    else if (en)
      pred_d = (count == 4'd9) ? 4'd0 : count + 4'd1;
    else
      pred_d = count;

    state_d = state;
    mcnt_d  = mcnt;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!is_illegal) begin
          state_d = TRAIN;
          mcnt_d  = '0;
        end
      end
      TRAIN: begin
        if (is_illegal) begin
          state_d = IDLE;
        end else if (is_match) begin
          if (mcnt == MW'(LOCK_LEN - 1)) begin
            state_d = LOCKED;
            mcnt_d  = '0;
          end else begin
            mcnt_d = mcnt + MW'(1);
          end
        end else begin
          mcnt_d = '0;
        end
      end
      LOCKED: begin
        if (is_illegal) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!is_match) begin
          state_d = TRAIN;
          mcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          wrap_d = prev_nine && (count == 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mcnt       <= '0;
      prev_nine  <= 1'b0;
      expected   <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state     <= state_d;
      mcnt      <= mcnt_d;
      prev_nine <= en && (count == 4'd9);
      expected  <= pred_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
      illegal   <= is_illegal;

      // An event coinciding with clear wins: the counter restarts at 1.
      if (err_d) begin
        err_sticky <= 1'b1;
        if (clear)
          err_count <= ERR_W'(1);
        else if (err_count != '1)
          err_count <= err_count + ERR_W'(1);
      end else if (clear) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      if (wrap_d) begin
        if (clear)
          wrap_count <= WRAP_W'(1);
        else if (wrap_count != '1)
          wrap_count <= wrap_count + WRAP_W'(1);
      end else if (clear) begin
        wrap_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decade_count_monitor.sv
// tb/tb_decade_count_monitor.sv - directed bench with run-length reference model
module tb_decade_count_monitor;

  localparam int LOCK_LEN = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  count = 4'd0;
  logic        clear = 1'b0;

  logic [3:0]  expected, expected2;
  logic        locked, err_pulse, err_sticky, illegal;
  logic        locked2, err_pulse2, err_sticky2, illegal2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic [15:0] wrap_count, wrap_count2;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  decade_count_monitor #(.LOCK_LEN(LOCK_LEN), .ERR_W(8), .WRAP_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .count(count), .clear(clear),
    .expected(expected), .locked(locked), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_count(err_count), .wrap_count(wrap_count),
    .illegal(illegal)
  );

  decade_count_monitor #(.LOCK_LEN(LOCK_LEN), .ERR_W(2), .WRAP_W(16)) dut2 (
    .clock(clock), .reset_n(reset_n), .en(en), .count(count), .clear(clear),
    .expected(expected2), .locked(locked2), .err_pulse(err_pulse2),
    .err_sticky(err_sticky2), .err_count(err_count2), .wrap_count(wrap_count2),
    .illegal(illegal2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_of(input bit e, input int c);
    return e ? (c + 1) % 10 : c;
  endfunction

  function automatic int sat_upd(input int cur, input bit ev, input bit clr, input int max);
    if (ev) return clr ? 1 : (cur < max ? cur + 1 : max);
    return clr ? 0 : cur;
  endfunction

  // Model: lock means the last LOCK_LEN transitions all matched, anchored on a legal sample.
  int  m_run;
  bit  m_pv, m_pen;
  int  m_pc;
  int  m_exp;
  bit  m_errp, m_ill, m_sticky;
  int  m_err8, m_err2, m_wrap;

  always @(posedge clock or negedge reset_n) begin : model
    bit ill, was_locked, match, ev_err, ev_wrap;
    int run;
    if (!reset_n) begin
      m_run <= -1; m_pv <= 0; m_pen <= 0; m_pc <= 0; m_exp <= 0;
      m_errp <= 0; m_ill <= 0; m_sticky <= 0;
      m_err8 <= 0; m_err2 <= 0; m_wrap <= 0;
    end else begin
      ill        = (count > 9);
      was_locked = (m_run >= LOCK_LEN);
      match      = m_pv && (int'(count) == next_of(m_pen, m_pc));
      if (ill)          run = -1;
      else if (!m_pv)   run = 0;
      else if (match)   run = (m_run < LOCK_LEN) ? m_run + 1 : LOCK_LEN;
      else              run = 0;
      ev_err  = was_locked && (ill || !match);
      ev_wrap = was_locked && match && m_pen && (m_pc == 9) && (count == 0);
      m_run    <= run;
      m_pv     <= !ill;
      m_pen    <= en;
      m_pc     <= int'(count);
      m_exp    <= ill ? 0 : next_of(en, int'(count));
      m_errp   <= ev_err;
      m_ill    <= ill;
      m_sticky <= ev_err ? 1'b1 : (clear ? 1'b0 : m_sticky);
      m_err8   <= sat_upd(m_err8, ev_err, clear, 255);
      m_err2   <= sat_upd(m_err2, ev_err, clear, 3);
      m_wrap   <= sat_upd(m_wrap, ev_wrap, clear, 65535);
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("expected",   int'(expected),   m_exp);
      chk("locked",     int'(locked),     int'(m_run >= LOCK_LEN));
      chk("err_pulse",  int'(err_pulse),  int'(m_errp));
      chk("err_sticky", int'(err_sticky), int'(m_sticky));
      chk("err_count",  int'(err_count),  m_err8);
      chk("wrap_count", int'(wrap_count), m_wrap);
      chk("illegal",    int'(illegal),    int'(m_ill));
      chk("err_count_w2", int'(err_count2), m_err2);
      chk("locked_w2",  int'(locked2),    int'(m_run >= LOCK_LEN));
    end
  end

  // Drive one sample from just after a falling edge; return at the next falling edge.
  task automatic step(input bit e, input int c, input bit cl);
    en = e; count = 4'(c); clear = cl;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk_on  = 1'b1;
    chk("lit_reset_locked", int'(locked), 0);
    chk("lit_reset_expected", int'(expected), 0);

    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0);
      if (i == 4) chk("lit_lock_edge4", int'(locked), 0);
      if (i == 5) chk("lit_lock_edge5", int'(locked), 1);
    end
    chk("lit_hold_expected", int'(expected), 0);
    chk("lit_hold_sticky", int'(err_sticky), 0);

    for (int i = 0; i < 25; i++) step(1, i % 10, 0);
    chk("lit_wrap_two", int'(wrap_count), 2);
    chk("lit_wrap_noerr", int'(err_count), 0);

    step(1, 3, 0);
    chk("lit_inj_pulse", int'(err_pulse), 1);
    chk("lit_inj_count", int'(err_count), 1);
    chk("lit_inj_locked", int'(locked), 0);
    step(1, 5, 0);
    chk("lit_inj_pulse_off", int'(err_pulse), 0);
    for (int v = 6; v <= 9; v++) begin
      step(1, v, 0);
      if (v == 8) chk("lit_relock_3", int'(locked), 0);
      if (v == 9) chk("lit_relock_4", int'(locked), 1);
    end
    step(1, 0, 0);
    chk("lit_wrap_three", int'(wrap_count), 3);

    step(1, 12, 0);
    chk("lit_ill_pulse", int'(illegal), 1);
    chk("lit_ill_err", int'(err_pulse), 1);
    chk("lit_ill_count", int'(err_count), 2);
    chk("lit_ill_expected", int'(expected), 0);
    step(1, 12, 0);
    chk("lit_idle_ill", int'(illegal), 1);
    chk("lit_idle_noerr", int'(err_pulse), 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0);
      if (i == 4) chk("lit_ill_relock4", int'(locked), 0);
      if (i == 5) chk("lit_ill_relock5", int'(locked), 1);
    end

    for (int k = 0; k < 3; k++) begin
      int v;
      v = (k % 2 == 1) ? 3 : 7;
      repeat (5) step(0, v, 0);
    end
    chk("lit_sat_w2", int'(err_count2), 3);
    chk("lit_sat_w8", int'(err_count), 5);

    step(0, 7, 1);
    chk("lit_clear_count", int'(err_count), 0);
    chk("lit_clear_sticky", int'(err_sticky), 0);
    chk("lit_clear_locked", int'(locked), 1);
    step(0, 2, 1);
    chk("lit_clr_err_w2", int'(err_count2), 1);
    chk("lit_clr_err_sticky", int'(err_sticky2), 1);

    for (int v = 2; v <= 10; v++) step(1, v % 10, 0);
    chk("lit_pre_reset_wrap", int'(wrap_count), 1);

    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_expected", int'(expected), 0);
    chk("lit_async_locked", int'(locked), 0);
    chk("lit_async_errp", int'(err_pulse), 0);
    chk("lit_async_sticky", int'(err_sticky), 0);
    chk("lit_async_errcnt", int'(err_count), 0);
    chk("lit_async_wrap", int'(wrap_count), 0);
    chk("lit_async_illegal", int'(illegal), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0);
      if (i == 4) chk("lit_post_reset4", int'(locked), 0);
      if (i == 5) chk("lit_post_reset5", int'(locked), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
